// File: rtl/trigger_seq_node.sv
// Multi-stage sequential trigger and capture-address generator for the on-chip logic watcher.
// Probe samples are registered (s1) and delayed (s0); each stage in turn is matched against them.
module trigger_seq_node #(
    parameter int unsigned DET_NUM = 32,
    parameter int unsigned STAGES  = 4,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        trig_clk,
    input  logic                        trig_rstn,
    input  logic                        arm,
    input  logic                        abort,
    input  logic                        pause,
    input  logic [DET_NUM-1:0]          trig_din,
    input  logic [STAGES*DET_NUM*3-1:0] trig_edge_mode,
    input  logic [STAGES*2-1:0]         trig_logic,
    input  logic [STAGES*CNT_W-1:0]     stage_count,
    input  logic [2:0]                  stage_num,
    input  logic [ADDR_W-1:0]           post_len,
    output logic                        wt_en,
    output logic [ADDR_W-1:0]           wt_addr,
    output logic [ADDR_W-1:0]           stop_addr,
    output logic                        stop_flag,
    output logic                        overflow_flag,
    output logic [2:0]                  cur_stage,
    output logic                        busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_POST = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int unsigned MIDX_W = $clog2(STAGES * DET_NUM * 3);
    localparam int unsigned LIDX_W = $clog2(STAGES * 2);
    localparam int unsigned CIDX_W = $clog2(STAGES * CNT_W);
    localparam logic [2:0]        LAST_MAX = 3'(STAGES - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [1:0]         state_q, state_d;
    logic [DET_NUM-1:0] s1_q, s1_d, s0_q, s0_d;
    logic               first_q, first_d;
    logic [ADDR_W-1:0]  addr_q, addr_d, stop_addr_q, stop_addr_d, post_q, post_d;
    logic               stop_q, stop_d, ovf_q, ovf_d, busy_q, busy_d;
    logic [2:0]         stage_q, stage_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MIDX_W-1:0]      midx;
    logic [LIDX_W-1:0]      lidx;
    logic [CIDX_W-1:0]      cidx;
    logic [DET_NUM*3-1:0]   mvec;
    logic [DET_NUM-1:0]     care, hit;
    logic [1:0]             lsel;
    logic                   all_hit, any_hit, match;
    logic [CNT_W-1:0]       tgt_raw, target, cnt_inc;
    logic [2:0]             last_stage;

    // Only the stage currently being searched is decoded.
    assign midx = MIDX_W'(32'(stage_q) * DET_NUM * 3);
    assign lidx = LIDX_W'(32'(stage_q) * 2);
    assign cidx = CIDX_W'(32'(stage_q) * CNT_W);
    assign mvec = trig_edge_mode[midx +: DET_NUM*3];
    assign lsel = trig_logic[lidx +: 2];

    for (genvar b = 0; b < DET_NUM; b++) begin : g_bit
        logic [2:0] m;
        assign m       = mvec[3*b +: 3];
        assign care[b] = (m >= 3'd1) && (m <= 3'd5);
        // Edge modes need a valid s0, which the first post-arm sample lacks.
        assign hit[b]  = (m == 3'd1) ? ~s1_q[b] :
                         (m == 3'd2) ?  s1_q[b] :
                         (m == 3'd3) ? (~first_q & ~s0_q[b] &  s1_q[b]) :
                         (m == 3'd4) ? (~first_q &  s0_q[b] & ~s1_q[b]) :
                         (m == 3'd5) ? (~first_q & (s0_q[b] ^ s1_q[b])) : 1'b0;
    end

    assign all_hit = &(hit | ~care);
    assign any_hit = |(hit & care);
    assign match   = (care == '0) ? 1'b1 :
                     (lsel == 2'b00) ? all_hit :
                     (lsel == 2'b01) ? any_hit :
                     (lsel == 2'b10) ? ~all_hit : ~any_hit;

    assign tgt_raw    = stage_count[cidx +: CNT_W];
    assign target     = (tgt_raw == '0) ? CNT_W'(1) : tgt_raw;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign last_stage = (stage_num > LAST_MAX) ? LAST_MAX : stage_num;

    always_ff @(posedge trig_clk or negedge trig_rstn) begin
        if (!trig_rstn) begin
            state_q     <= ST_IDLE;
            s1_q        <= '0;
            s0_q        <= '0;
            first_q     <= 1'b0;
            addr_q      <= '0;
            stop_addr_q <= '0;
            post_q      <= '0;
            stop_q      <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            stage_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s0_q        <= s0_d;
            first_q     <= first_d;
            addr_q      <= addr_d;
            stop_addr_q <= stop_addr_d;
            post_q      <= post_d;
            stop_q      <= stop_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            stage_q     <= stage_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s1_d        = s1_q;
        s0_d        = s0_q;
        first_d     = first_q;
        addr_d      = addr_q;
        stop_addr_d = stop_addr_q;
        post_d      = post_q;
        stop_d      = stop_q;
        ovf_d       = ovf_q;
        stage_d     = stage_q;
        cnt_d       = cnt_q;
        wt_en       = 1'b0;

        if (!pause) begin
            s1_d = trig_din;
            s0_d = s1_q;
        end

        if (abort) begin
            state_d = ST_IDLE;
            stage_d = '0;
            cnt_d   = '0;
        end else if (!pause) begin
            case (state_q)
                ST_PRE: begin
                    wt_en   = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    first_d = 1'b0;
                    if (addr_q == ADDR_MAX) ovf_d = 1'b1;
                    if (match) begin
                        if (cnt_inc != target) begin
                            cnt_d = cnt_inc;
                        end else if (stage_q != last_stage) begin
                            stage_d = stage_q + 3'd1;
                            cnt_d   = '0;
                        end else begin
                            // post_len is ADDR_W wide, so it can never exceed depth-1.
                            stop_addr_d = addr_q;
                            post_d      = post_len;
                            cnt_d       = '0;
                            if (post_len == '0) begin
                                state_d = ST_DONE;
                                stop_d  = 1'b1;
                            end else begin
                                state_d = ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    wt_en  = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    post_d = post_q - ADDR_W'(1);
                    if (post_q == ADDR_W'(1)) begin
                        state_d = ST_DONE;
                        stop_d  = 1'b1;
                    end
                end
                default: begin
                    if (arm) begin
                        state_d = ST_PRE;
                        addr_d  = '0;
                        stage_d = '0;
                        cnt_d   = '0;
                        stop_d  = 1'b0;
                        ovf_d   = 1'b0;
                        first_d = 1'b1;
                    end
                end
            endcase
        end

        busy_d = (state_d == ST_PRE) || (state_d == ST_POST);
    end

    assign wt_addr       = addr_q;
    assign stop_addr     = stop_addr_q;
    assign stop_flag     = stop_q;
    assign overflow_flag = ovf_q;
    assign cur_stage     = stage_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_trigger_seq_node.sv
// Scenario bench for trigger_seq_node: expected write addresses are queued up front
// and popped by a negedge monitor as the DUT asserts wt_en.
module tb_trigger_seq_node;
    localparam int unsigned DET_NUM = 8;
    localparam int unsigned STAGES  = 4;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned NS      = 2300;
    localparam int unsigned MIDX_W  = $clog2(STAGES * DET_NUM * 3);
    localparam int unsigned LIDX_W  = $clog2(STAGES * 2);
    localparam int unsigned CIDX_W  = $clog2(STAGES * CNT_W);

    logic                        clk = 1'b0;
    logic                        trig_rstn;
    logic                        arm, abort, pause;
    logic [DET_NUM-1:0]          trig_din;
    logic [STAGES*DET_NUM*3-1:0] trig_edge_mode;
    logic [STAGES*2-1:0]         trig_logic;
    logic [STAGES*CNT_W-1:0]     stage_count;
    logic [2:0]                  stage_num;
    logic [ADDR_W-1:0]           post_len;
    logic                        wt_en;
    logic [ADDR_W-1:0]           wt_addr, stop_addr;
    logic                        stop_flag, overflow_flag, busy;
    logic [2:0]                  cur_stage;

    logic [DET_NUM-1:0] samp [NS];
    bit                 pz [NS];
    bit                 ab [NS];
    bit                 am [NS];
    logic [2:0]         stage_log [NS];
    logic [ADDR_W-1:0]  addr_log [NS];
    logic [ADDR_W-1:0]  exp_q [$];
    logic [ADDR_W-1:0]  mon_e;
    int total = 0;
    int bad   = 0;

    trigger_seq_node #(
        .DET_NUM(DET_NUM), .STAGES(STAGES), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .trig_clk(clk), .trig_rstn(trig_rstn), .arm(arm), .abort(abort), .pause(pause),
        .trig_din(trig_din), .trig_edge_mode(trig_edge_mode), .trig_logic(trig_logic),
        .stage_count(stage_count), .stage_num(stage_num), .post_len(post_len),
        .wt_en(wt_en), .wt_addr(wt_addr), .stop_addr(stop_addr), .stop_flag(stop_flag),
        .overflow_flag(overflow_flag), .cur_stage(cur_stage), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Every write must match the next queued address.
    always @(negedge clk) begin
        if (trig_rstn === 1'b1 && wt_en === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL write_unexpected got=%0d exp=none", wt_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (wt_addr !== mon_e) begin
                    bad++;
                    $display("FAIL write_addr got=%0d exp=%0d", wt_addr, mon_e);
                end
            end
        end
    end

    task automatic cfg_clear();
        trig_edge_mode = '0;
        trig_logic     = '0;
        stage_count    = '0;
        stage_num      = 3'd0;
        post_len       = '0;
        for (int k = 0; k < int'(NS); k++) begin
            samp[k] = '0; pz[k] = 1'b0; ab[k] = 1'b0; am[k] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic set_mode(input int s, input int b, input logic [2:0] m);
        trig_edge_mode[MIDX_W'((s * int'(DET_NUM) + b) * 3) +: 3] = m;
    endtask

    task automatic set_logic(input int s, input logic [1:0] l);
        trig_logic[LIDX_W'(s * 2) +: 2] = l;
    endtask

    task automatic set_count(input int s, input logic [CNT_W-1:0] c);
        stage_count[CIDX_W'(s * int'(CNT_W)) +: CNT_W] = c;
    endtask

    task automatic push_range(input int lo, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(ADDR_W'((lo + i) % 1024));
    endtask

    // One idle cycle of zero data, arm with samp[0], then one cycle per iteration.
    task automatic run(input int budget, output bit ok, output int stop_cyc);
        ok = 1'b0;
        stop_cyc = -1;
        trig_din = '0; arm = 1'b0; pause = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        arm = 1'b1; trig_din = samp[0];
        @(posedge clk); #1;
        arm = 1'b0;
        for (int k = 0; k < budget; k++) begin
            stage_log[k] = cur_stage;
            addr_log[k]  = wt_addr;
            if (stop_flag === 1'b1) begin
                ok = 1'b1;
                stop_cyc = k;
                break;
            end
            trig_din = samp[k+1]; pause = pz[k]; abort = ab[k]; arm = am[k];
            @(posedge clk); #1;
        end
        pause = 1'b0; abort = 1'b0; arm = 1'b0;
    endtask

    task automatic test_reset();
        trig_rstn = 1'b0; arm = 1'b0; abort = 1'b0; pause = 1'b0; trig_din = '0;
        cfg_clear();
        #12;
        total++;
        if ({wt_en, wt_addr, stop_addr, stop_flag, overflow_flag, cur_stage, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {wt_en, wt_addr, stop_addr, stop_flag, overflow_flag, cur_stage, busy});
        end
        @(posedge clk); #1;
        trig_rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({wt_en, busy, stop_flag} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=000", {wt_en, busy, stop_flag});
        end
    endtask

    task automatic test_one_stage();
        bit ok; int sc;
        cfg_clear();
        set_mode(0, 0, 3'b011);
        set_count(0, 8'd1);
        post_len = ADDR_W'(4);
        samp[0] = 8'h01;
        for (int k = 20; k < int'(NS); k++) samp[k] = 8'h01;
        push_range(0, 25);
        run(100, ok, sc);
        total++;
        if (!ok || sc != 25) begin bad++; $display("FAIL t1_stop_cycle got=%0d exp=25", sc); end
        total++;
        if (stop_addr !== ADDR_W'(20)) begin bad++; $display("FAIL t1_stop_addr got=%0d exp=20", stop_addr); end
        total++;
        if (overflow_flag !== 1'b0) begin bad++; $display("FAIL t1_overflow got=%b exp=0", overflow_flag); end
        total++;
        if ({busy, wt_en} !== 2'b00) begin bad++; $display("FAIL t1_done_idle got=%b exp=00", {busy, wt_en}); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL t1_writes_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_multi_stage();
        bit ok; int sc;
        cfg_clear();
        set_mode(0, 1, 3'b010);
        set_mode(1, 2, 3'b100);
        set_mode(2, 3, 3'b011);
        set_count(0, 8'd2); set_count(1, 8'd1); set_count(2, 8'd1);
        stage_num = 3'd2;
        post_len  = ADDR_W'(2);
        for (int k = 0; k < int'(NS); k++) begin
            logic [DET_NUM-1:0] v;
            v = '0;
            if (k == 5 || k == 6 || k == 16 || k == 17) v[2] = 1'b1;
            if (k == 6 || k >= 20) v[3] = 1'b1;
            if (k == 10 || k >= 14) v[1] = 1'b1;
            samp[k] = v;
        end
        am[12] = 1'b1;
        push_range(0, 23);
        run(100, ok, sc);
        total++;
        if (stage_log[14] !== 3'd0) begin bad++; $display("FAIL t2_stage_c14 got=%0d exp=0", stage_log[14]); end
        total++;
        if (stage_log[15] !== 3'd1) begin bad++; $display("FAIL t2_stage_c15 got=%0d exp=1", stage_log[15]); end
        total++;
        if (stage_log[18] !== 3'd1) begin bad++; $display("FAIL t2_stage_c18 got=%0d exp=1", stage_log[18]); end
        total++;
        if (stage_log[19] !== 3'd2) begin bad++; $display("FAIL t2_stage_c19 got=%0d exp=2", stage_log[19]); end
        total++;
        if (!ok || sc != 23) begin bad++; $display("FAIL t2_stop_cycle got=%0d exp=23", sc); end
        total++;
        if (stop_addr !== ADDR_W'(20)) begin bad++; $display("FAIL t2_stop_addr got=%0d exp=20", stop_addr); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL t2_writes_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        bit ok; int sc;
        cfg_clear();
        set_mode(0, 0, 3'b011);
        set_mode(0, 1, 3'b011);
        set_logic(0, 2'b01);
        set_count(0, 8'd1);
        post_len = '1;
        for (int k = 1100; k < int'(NS); k++) samp[k] = 8'h01;
        push_range(0, 2124);
        run(2200, ok, sc);
        total++;
        if (!ok || sc != 2124) begin bad++; $display("FAIL t3_stop_cycle got=%0d exp=2124", sc); end
        total++;
        if (stop_addr !== ADDR_W'(76)) begin bad++; $display("FAIL t3_stop_addr got=%0d exp=76", stop_addr); end
        total++;
        if (overflow_flag !== 1'b1) begin bad++; $display("FAIL t3_overflow got=%b exp=1", overflow_flag); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL t3_writes_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_pause();
        bit ok; int sc;
        cfg_clear();
        set_mode(0, 0, 3'b011);
        samp[9] = 8'h01;
        for (int k = 12; k < int'(NS); k++) samp[k] = 8'h01;
        for (int k = 8; k <= 12; k++) pz[k] = 1'b1;
        push_range(0, 10);
        run(100, ok, sc);
        total++;
        if (addr_log[12] !== ADDR_W'(8)) begin bad++; $display("FAIL t4_addr_hold got=%0d exp=8", addr_log[12]); end
        total++;
        if (addr_log[14] !== ADDR_W'(9)) begin bad++; $display("FAIL t4_addr_resume got=%0d exp=9", addr_log[14]); end
        total++;
        if (!ok || sc != 15) begin bad++; $display("FAIL t4_stop_cycle got=%0d exp=15", sc); end
        total++;
        if (stop_addr !== ADDR_W'(9)) begin bad++; $display("FAIL t4_stop_addr got=%0d exp=9", stop_addr); end
        total++;
        if (overflow_flag !== 1'b0) begin bad++; $display("FAIL t4_overflow_cleared got=%b exp=0", overflow_flag); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL t4_writes_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_abort_rearm();
        bit ok; int sc;
        cfg_clear();
        set_mode(0, 0, 3'b011);
        for (int k = 10; k < int'(NS); k++) samp[k] = 8'h01;
        ab[10] = 1'b1;
        push_range(0, 10);
        run(20, ok, sc);
        total++;
        if (ok) begin bad++; $display("FAIL t5_abort_stopped got=%0d exp=-1", sc); end
        total++;
        if ({stop_flag, busy, cur_stage} !== 5'b0) begin
            bad++; $display("FAIL t5_abort_idle got=%b exp=00000", {stop_flag, busy, cur_stage});
        end
        total++;
        if (stop_addr !== ADDR_W'(9)) begin bad++; $display("FAIL t5_stop_addr_hold got=%0d exp=9", stop_addr); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL t5_writes_left got=%0d exp=0", exp_q.size()); end

        cfg_clear();
        set_mode(0, 4, 3'b001);
        set_mode(0, 5, 3'b001);
        set_logic(0, 2'b11);
        post_len = ADDR_W'(1);
        for (int k = 5; k < int'(NS); k++) samp[k] = 8'h30;
        push_range(0, 7);
        run(100, ok, sc);
        total++;
        if (!ok || sc != 7) begin bad++; $display("FAIL t5_rearm_stop_cycle got=%0d exp=7", sc); end
        total++;
        if (stop_addr !== ADDR_W'(5)) begin bad++; $display("FAIL t5_rearm_stop_addr got=%0d exp=5", stop_addr); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL t5_rearm_writes_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_in_post();
        bit ok; int sc;
        cfg_clear();
        set_count(0, 8'd5);
        set_mode(1, 0, 3'b010);
        stage_num = 3'd1;
        post_len  = ADDR_W'(50);
        for (int k = 0; k < int'(NS); k++) samp[k] = 8'h01;
        push_range(0, 10);
        run(10, ok, sc);
        total++;
        if ({busy, cur_stage} !== 4'b1001) begin bad++; $display("FAIL t6_in_post got=%b exp=1001", {busy, cur_stage}); end
        total++;
        if (stop_addr !== ADDR_W'(5)) begin bad++; $display("FAIL t6_stop_addr got=%0d exp=5", stop_addr); end
        trig_rstn = 1'b0;
        #1;
        total++;
        if ({wt_en, wt_addr, stop_addr, stop_flag, overflow_flag, cur_stage, busy} !== '0) begin
            bad++;
            $display("FAIL t6_async_reset got=%h exp=0",
                     {wt_en, wt_addr, stop_addr, stop_flag, overflow_flag, cur_stage, busy});
        end
        repeat (2) @(posedge clk);
        #1;
        trig_rstn = 1'b1;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL t6_writes_left got=%0d exp=0", exp_q.size()); end

        cfg_clear();
        set_mode(0, 2, 3'b010);
        set_mode(0, 3, 3'b010);
        set_logic(0, 2'b01);
        set_count(0, 8'd1);
        post_len = ADDR_W'(3);
        for (int k = 7; k < int'(NS); k++) samp[k] = 8'h08;
        push_range(0, 11);
        run(100, ok, sc);
        total++;
        if (!ok || sc != 11) begin bad++; $display("FAIL t6_rearm_stop_cycle got=%0d exp=11", sc); end
        total++;
        if (stop_addr !== ADDR_W'(7)) begin bad++; $display("FAIL t6_rearm_stop_addr got=%0d exp=7", stop_addr); end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL t6_rearm_writes_left got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_one_stage();
        test_multi_stage();
        test_overflow();
        test_pause();
        test_abort_rearm();
        test_reset_in_post();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
